// File: rtl/gen_for_pkg.sv
// rtl/gen_for_pkg.sv - shared state enum and constants for gen_for_seq
package gen_for_pkg;

  // Controller states: wait for operands, iterate, present result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Accumulator start value loaded on reset (and on each transfer unless persisting).
  localparam int INIT_TEMP    = 1;
  // Default constant subtracted from the accumulator to form the result.
  localparam int DEFAULT_BIAS = 17;

endpackage

// File: rtl/gen_for_seq_if.sv
// rtl/gen_for_seq_if.sv - operand/result handshake bundle for gen_for_seq
//
// Signals:
//   IN_VALID / IN_READY   operand pair handshake (A, B)
//   OUT_VALID / OUT_READY result handshake (XOUT)
//   BUSY                  block is not idle
// Modports: master = operand producer / result consumer, slave = gen_for_seq.
interface gen_for_seq_if #(
  parameter int NBITS = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [NBITS-1:0] A;
  logic [NBITS-1:0] B;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [NBITS-1:0] XOUT;
  logic             BUSY;

  modport master (
    output IN_VALID, A, B, OUT_READY,
    input  IN_READY, OUT_VALID, XOUT, BUSY
  );

  modport slave (
    input  IN_VALID, A, B, OUT_READY,
    output IN_READY, OUT_VALID, XOUT, BUSY
  );
endinterface

// File: rtl/gen_for_step.sv
// rtl/gen_for_step.sv - one accumulator iteration: add (A+B) on even index, (A-B) on odd
//
// Ports:
//   i_temp  current accumulator
//   i_a/i_b latched operands
//   i_odd   low bit of the iteration index
//   o_temp  next accumulator (all arithmetic wraps modulo 2^NBITS)
module gen_for_step #(
  parameter int NBITS = 8
) (
  input  logic [NBITS-1:0] i_temp,
  input  logic [NBITS-1:0] i_a,
  input  logic [NBITS-1:0] i_b,
  input  logic             i_odd,
  output logic [NBITS-1:0] o_temp
);

  logic [NBITS-1:0] w_sum;
  logic [NBITS-1:0] w_diff;
  logic [NBITS-1:0] w_term;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_term = i_odd ? w_diff : w_sum;
  assign o_temp = i_temp + w_term;

endmodule

// File: rtl/gen_for_seq.sv
// rtl/gen_for_seq.sv - iterative accumulate sequencer: COUNT steps over latched A/B, result TEMP-BIAS
//
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  gen_for_seq_if.slave (IN_VALID/IN_READY/A/B, OUT_VALID/OUT_READY/XOUT, BUSY)
// Configuration macro: GEN_FOR_SEQ_PERSIST_EN
//   defined   - accumulator carries over between transactions (cleared only by RST)
//   undefined - accumulator reloaded to INIT_TEMP on every operand transfer
module gen_for_seq
  import gen_for_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int COUNT = 4,
  parameter int BIAS  = DEFAULT_BIAS
) (
  input  logic         CLK,
  input  logic         RST,
  gen_for_seq_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_b;
  logic [NBITS-1:0] r_temp;
  logic [7:0]       r_idx;
  logic [NBITS-1:0] r_xout;

  logic [NBITS-1:0] w_temp_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  gen_for_step #(.NBITS(NBITS)) u_step (
    .i_temp (r_temp),
    .i_a    (r_a),
    .i_b    (r_b),
    .i_odd  (r_idx[0]),
    .o_temp (w_temp_nxt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs decode straight from the state register so RST
  // takes them to their idle values without waiting for a clock edge.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.IN_VALID) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_idx == 8'(COUNT - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // IN_READY stays low here, so the earliest next accept is the
        // cycle after returning to IDLE.
        w_out_valid = 1'b1;
        if (bus.OUT_READY) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a    <= '0;
      r_b    <= '0;
      r_temp <= NBITS'(INIT_TEMP);
      r_idx  <= '0;
      r_xout <= '0;
    end else if (w_accept) begin
      r_a   <= bus.A;
      r_b   <= bus.B;
      r_idx <= '0;
`ifdef GEN_FOR_SEQ_PERSIST_EN
      // Accumulator deliberately left untouched: it continues from the
      // previous transaction's final value.
`else
      r_temp <= NBITS'(INIT_TEMP);
`endif
    end else if (r_state == ST_RUN) begin
      r_temp <= w_temp_nxt;
      r_idx  <= r_idx + 8'd1;
      if (w_last) begin
        r_xout <= w_temp_nxt - NBITS'(BIAS);
      end
    end
  end

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_VALID = w_out_valid;
  assign bus.BUSY      = w_busy;
  assign bus.XOUT      = r_xout;

endmodule

// File: tb/tb_gen_for_seq.sv
// tb/tb_gen_for_seq.sv - self-checking bench for gen_for_seq (NBITS=8, COUNT=4, BIAS=17)
module tb_gen_for_seq;

  localparam int NB  = 8;
  localparam int CNT = 4;
  localparam int BS  = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gen_for_seq_if #(.NBITS(NB)) bus ();

  gen_for_seq #(.NBITS(NB), .COUNT(CNT), .BIAS(BS)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int            vectors     = 0;
  int            miscompares = 0;
  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] model_temp;
  logic [NB-1:0] last_x;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the COUNT iterations on 8-bit variables.
  task automatic predict(input logic [NB-1:0] a, input logic [NB-1:0] b, output logic [NB-1:0] x);
    logic [NB-1:0] s;
    logic [NB-1:0] d;
    s = a + b;
    d = a - b;
`ifndef GEN_FOR_SEQ_PERSIST_EN
    model_temp = 8'd1;
`endif
    for (int i = 0; i < CNT; i++) begin
      model_temp = model_temp + (((i % 2) == 1) ? d : s);
    end
    x = model_temp - 8'(BS);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_temp = 8'd1;
    exp_q.delete();
  endtask

  task automatic start(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int n;
    logic [NB-1:0] x;
    n = 0;
    while (bus.IN_READY !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", 32'(bus.IN_READY), 32'd1);
    bus.A = a;
    bus.B = b;
    bus.IN_VALID = 1'b1;
    predict(a, b, x);
    exp_q.push_back(x);
    @(posedge clk); #1;
    bus.IN_VALID = 1'b0;
    // Operands are latched; scribbling the inputs must not matter.
    bus.A = NB'($urandom);
    bus.B = NB'($urandom);
    check("busy_after_accept", 32'(bus.BUSY), 32'd1);
  endtask

  task automatic wait_out();
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.OUT_VALID !== 1'b1 && lat < 20);
    check("out_valid_latency", 32'(lat), 32'(CNT));
  endtask

  task automatic complete(input string tag);
    logic [NB-1:0] x;
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      x = 'x;
    end else begin
      x = exp_q.pop_front();
      check({tag, "_xout"}, 32'(bus.XOUT), 32'(x));
    end
    last_x = x;
    bus.OUT_READY = 1'b1;
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
    check({tag, "_idle_out_valid"}, 32'(bus.OUT_VALID), 32'd0);
    check({tag, "_idle_in_ready"}, 32'(bus.IN_READY), 32'd1);
    check({tag, "_xout_retained"}, 32'(bus.XOUT), 32'(last_x));
  endtask

  initial begin
    int seen;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    model_temp    = 8'd1;
    last_x        = '0;

    // Asynchronous reset seen before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", 32'(bus.IN_READY), 32'd1);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst_xout", 32'(bus.XOUT), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic transaction: 5,3 -> 4.
    start(8'd5, 8'd3);
    wait_out();
    complete("t1_5_3");

    // Second 5,3: 24 when persisting, else 4.
    start(8'd5, 8'd3);
    wait_out();
    complete("t2_5_3");

    // Wraparound A<B from reset: 252.
    do_reset();
    start(8'd3, 8'd5);
    wait_out();
    complete("t3_3_5");

    // Large operands from reset: 16.
    do_reset();
    start(8'd200, 8'd10);
    wait_out();
    complete("t4_200_10");

    // DONE held with OUT_READY low for 10 cycles while IN_VALID pulses.
    do_reset();
    start(8'd5, 8'd3);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      bus.IN_VALID = i[0];
      bus.A = NB'($urandom);
      bus.B = NB'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", 32'(bus.OUT_VALID), 32'd1);
      check("hold_xout", 32'(bus.XOUT), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hFFFF_FFFF);
      check("hold_in_ready", 32'(bus.IN_READY), 32'd0);
    end
    bus.IN_VALID = 1'b0;
    complete("t5_hold");

    // Reset between edges in RUN at IDX=2.
    start(8'd5, 8'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(bus.BUSY), 32'd0);
    check("midrun_rst_in_ready", 32'(bus.IN_READY), 32'd1);
    check("midrun_rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("midrun_rst_xout", 32'(bus.XOUT), 32'd0);
    rst = 1'b0;
    model_temp = 8'd1;
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.OUT_VALID === 1'b1) seen++;
    end
    check("midrun_no_out_valid", 32'(seen), 32'd0);
    start(8'd5, 8'd3);
    wait_out();
    complete("t6_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gen_for_seq.md
GEN_FOR_SEQ -- requirements
Module: gen_for_seq

Interface
REQ-001 SHALL have parameter NBITS, default 8, data width of A, B and XOUT.
REQ-002 SHALL have parameter COUNT, default 4, loop iteration count (legal range 1..255).
REQ-003 SHALL have parameter BIAS, default 17, constant subtracted from the accumulator to form XOUT.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 IN_VALID  input  1  A/B operand pair offered.
REQ-007 IN_READY  output  1  block can accept an operand pair.
REQ-008 A  input  NBITS  unsigned operand.
REQ-009 B  input  NBITS  unsigned operand.
REQ-010 OUT_VALID  output  1  XOUT holds a finished result.
REQ-011 OUT_READY  input  1  consumer takes the result.
REQ-012 XOUT  output  NBITS  result.
REQ-013 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL use three states: IDLE, RUN, DONE.
REQ-015 IN_READY SHALL be high only in IDLE; a transfer occurs on an edge with IN_VALID and IN_READY both high.
REQ-016 On transfer, SHALL latch A and B, clear iteration index IDX to 0, and enter RUN.
REQ-017 In RUN, each edge SHALL update TEMP to TEMP + (A+B) for even IDX, or to TEMP + (A-B) for odd IDX, then increment IDX.
REQ-018 All arithmetic SHALL be modulo 2^NBITS; A-B wraps when A<B; no saturation and no overflow flag.
REQ-019 After the edge that processes IDX = COUNT-1, SHALL enter DONE with XOUT = TEMP - BIAS (mod 2^NBITS) registered.
REQ-020 OUT_VALID SHALL rise exactly COUNT cycles after the transfer edge.
REQ-021 In DONE, OUT_VALID and XOUT SHALL hold stable until an edge with OUT_READY high, then return to IDLE.
REQ-022 An operand transfer SHALL NOT occur in the same cycle as the DONE->IDLE return; the next accept is one cycle later at the earliest.
REQ-023 IN_VALID and A/B changes during RUN or DONE SHALL be ignored.
REQ-024 XOUT SHALL retain its last value outside DONE.

Reset
REQ-025 RST high SHALL force the state to IDLE, TEMP=1, IDX=0, XOUT=0, OUT_VALID=0, BUSY=0 and IN_READY=1 immediately, without waiting for CLK.
REQ-026 RST asserted during RUN or DONE SHALL abandon the transaction; no OUT_VALID is produced for it.

Configuration
REQ-027 Macro GEN_FOR_SEQ_PERSIST_EN defined: TEMP SHALL carry over between transactions and reset only on RST.
REQ-028 Macro GEN_FOR_SEQ_PERSIST_EN undefined: TEMP SHALL be reloaded to 1 on every transfer edge.

Structure
REQ-029 The state enum and the constants INIT_TEMP=1 and DEFAULT_BIAS=17 SHALL live in shared package gen_for_pkg.
REQ-030 The per-iteration term select-and-add (even/odd, modulo add) SHALL be sub-module gen_for_step, instantiated once.

Verification (NBITS=8, COUNT=4, BIAS=17)
REQ-031 Reset, then A=5, B=3 -> OUT_VALID rises 4 cycles after accept with XOUT=4 (TEMP=21).
REQ-032 Second transaction A=5, B=3 -> XOUT=24 with PERSIST_EN defined; XOUT=4 with it undefined.
REQ-033 From reset, A=3, B=5 (A<B wrap) -> XOUT=252; from reset, A=200, B=10 -> XOUT=16.
REQ-034 OUT_READY held low for 10 cycles in DONE -> XOUT and OUT_VALID stable, IN_READY low, IN_VALID pulses ignored; OUT_READY high -> IDLE one edge later.
REQ-035 RST pulsed between clock edges during RUN at IDX=2 -> outputs take reset values at once; no OUT_VALID follows; next A=5, B=3 -> XOUT=4.
